// File: rtl/i8080_pkg.sv
`default_nettype none
// ==================================================================
// i8080_pkg : state encoding and timing defaults for i8080_tx
// Revision  : 1.0
// ==================================================================
package i8080_pkg;

  localparam int CNT_W       = 8;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_T_SETUP = 1;
  localparam int DEF_T_WRL   = 2;
  localparam int DEF_T_WRH   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    WR_LOW  = 2'd2,
    WR_HIGH = 2'd3
  } state_t;

  // The phase counter runs len-1 .. 0, so a phase of len cycles loads len-1.
  function automatic logic [CNT_W-1:0] phase_load(input int len);
    return CNT_W'(len - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i8080_tx.sv
`default_nettype none
// ==================================================================
// i8080_tx : i8080 write-only parallel transmitter with registered outputs
// Revision : 1.0
// ==================================================================
module i8080_tx
  import i8080_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_WRL   = DEF_T_WRL,
  parameter int T_WRH   = DEF_T_WRH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_dc,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              csx,
  output logic              dcx,
  output logic              wrx,
  output logic [DATA_W-1:0] db,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] c_setup_ld = phase_load(T_SETUP);
  localparam logic [CNT_W-1:0] c_wrl_ld   = phase_load(T_WRL);
  localparam logic [CNT_W-1:0] c_wrh_ld   = phase_load(T_WRH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              csx_q, csx_d;
  logic              dcx_q, dcx_d;
  logic              wrx_q, wrx_d;
  logic [DATA_W-1:0] db_q, db_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              in_ready_q, in_ready_d;
  logic              w_accept;

  assign w_accept = in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    csx_d   = csx_q;
    dcx_d   = dcx_q;
    wrx_d   = wrx_q;
    db_d    = db_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        csx_d = 1'b1;
        wrx_d = 1'b1;
        if (w_accept) begin
          state_d = SETUP;
          cnt_d   = c_setup_ld;
          csx_d   = 1'b0;
          dcx_d   = in_dc;
          db_d    = in_data;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = WR_LOW;
          cnt_d   = c_wrl_ld;
          wrx_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_LOW: begin
        if (cnt_q == '0) begin
          state_d = WR_HIGH;
          cnt_d   = c_wrh_ld;
          wrx_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (w_accept) begin
          // Back-to-back word: chip select stays asserted through the burst.
          state_d = SETUP;
          cnt_d   = c_setup_ld;
          dcx_d   = in_dc;
          db_d    = in_data;
        end else begin
          state_d = IDLE;
          csx_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        csx_d   = 1'b1;
        wrx_d   = 1'b1;
      end
    endcase

    // Ready is registered, so it is derived from where the FSM is headed.
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE) || ((state_d == WR_HIGH) && (cnt_d == '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      csx_q      <= 1'b1;
      dcx_q      <= 1'b1;
      wrx_q      <= 1'b1;
      db_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      csx_q      <= csx_d;
      dcx_q      <= dcx_d;
      wrx_q      <= wrx_d;
      db_q       <= db_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign csx      = csx_q;
  assign dcx      = dcx_q;
  assign wrx      = wrx_q;
  assign db       = db_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_i8080_tx.sv
`default_nettype none
// ==================================================================
// tb_i8080_tx : scoreboard bench for i8080_tx (default and swept timing)
// Revision    : 1.0
// ==================================================================
module tb_i8080_tx;

  typedef struct packed {
    int          gap;
    logic        dc;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  in_valid = '0;
  logic [1:0]  in_dc = '0;
  logic [15:0] in_data [2];
  logic [1:0]  in_ready, csx, dcx, wrx, busy, done;
  logic [15:0] db [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_done [2];
  int done_cnt  [2];
  int low_cnt   [2];
  int wrl_exp   [2];
  bit chk_csx   = 1'b0;
  int csx_breaks = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i8080_tx dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_dc(in_dc[0]),
    .in_data(in_data[0]), .in_ready(in_ready[0]), .csx(csx[0]), .dcx(dcx[0]),
    .wrx(wrx[0]), .db(db[0]), .busy(busy[0]), .done(done[0])
  );

  i8080_tx #(.DATA_W(16), .T_SETUP(3), .T_WRL(1), .T_WRH(4)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_dc(in_dc[1]),
    .in_data(in_data[1]), .in_ready(in_ready[1]), .csx(csx[1]), .dcx(dcx[1]),
    .wrx(wrx[1]), .db(db[1]), .busy(busy[1]), .done(done[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expected word on each done pulse; holds db/dcx against it while wrx is low.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        low_cnt[u] = 0;
      end else begin
        have = 1'b0;
        if (u == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
        if (u == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
        if (wrx[u] == 1'b0) begin
          low_cnt[u]++;
          check("wrlow_word_pending", 32'(have), 1);
          if (have) check("wrlow_db_dcx_hold", {dcx[u], db[u]}, {e.dc, e.data});
          check("wrlow_not_ready", 32'(in_ready[u]), 0);
        end
        if (done[u]) begin
          check("done_expected", 32'(have), 1);
          if (have) begin
            check("done_db", 32'(db[u]), 32'(e.data));
            check("done_dcx", 32'(dcx[u]), 32'(e.dc));
            check("done_wrx_high", 32'(wrx[u]), 1);
            check("done_csx_low", 32'(csx[u]), 0);
            check("wrx_low_len", low_cnt[u], wrl_exp[u]);
            if (e.gap != 0) check("word_period", cyc - last_done[u], e.gap);
            if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          end
          last_done[u] = cyc;
          low_cnt[u]   = 0;
          done_cnt[u]++;
        end
        if (u == 0 && chk_csx && csx[0]) csx_breaks++;
      end
    end
  end

  task automatic send(input int u, input logic dc, input logic [15:0] d, input int gap,
                      output int acc_cyc);
    exp_t e;
    bit   acc;
    int   n;
    e.gap = gap; e.dc = dc; e.data = d;
    if (u == 0) q0.push_back(e); else q1.push_back(e);
    in_valid[u] = 1'b1; in_dc[u] = dc; in_data[u] = d;
    acc = 1'b0; n = 0; acc_cyc = -1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc     = in_ready[u];
      acc_cyc = cyc;
      n++;
      @(posedge clk); #1;
    end
    in_valid[u] = 1'b0;
    check("send_accepted", 32'(acc), 1);
  endtask

  task automatic wait_done(input int u, input int target);
    for (int i = 0; i < 200 && done_cnt[u] < target; i++) @(posedge clk);
    #1;
    check("wait_done", done_cnt[u], target);
  endtask

  task automatic wait_wrx_low(input int u);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!wrx[u]) break;
    end
    check("wrx_went_low", 32'(wrx[u]), 0);
  endtask

  initial begin
    logic [5:0] csx_e, wrx_e, done_e, rdy_e, busy_e;
    int a, acc_b, base, lows;
    in_data[0] = '0; in_data[1] = '0;
    last_done[0] = 0; last_done[1] = 0;
    done_cnt[0]  = 0; done_cnt[1]  = 0;
    low_cnt[0]   = 0; low_cnt[1]   = 0;
    wrl_exp[0]   = 2; wrl_exp[1]   = 1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_csx", 32'(csx[u]), 1);
      check("rst_wrx", 32'(wrx[u]), 1);
      check("rst_dcx", 32'(dcx[u]), 1);
      check("rst_db", 32'(db[u]), 0);
      check("rst_done", 32'(done[u]), 0);
      check("rst_busy", 32'(busy[u]), 0);
      check("rst_ready", 32'(in_ready[u]), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(in_ready[0]), 1);
    check("ready_after_rst1", 32'(in_ready[1]), 1);

    // Single write, cycle-accurate waveform (index k = cycle k+1 after accept)
    @(posedge clk); #1;
    send(0, 1'b1, 16'h1234, 0, a);
    csx_e = 6'b100000; wrx_e = 6'b111001; done_e = 6'b001000;
    rdy_e = 6'b110000; busy_e = 6'b011111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("sw_csx", 32'(csx[0]), 32'(csx_e[k]));
      check("sw_wrx", 32'(wrx[0]), 32'(wrx_e[k]));
      check("sw_done", 32'(done[0]), 32'(done_e[k]));
      check("sw_ready", 32'(in_ready[0]), 32'(rdy_e[k]));
      check("sw_busy", 32'(busy[0]), 32'(busy_e[k]));
      check("sw_db", 32'(db[0]), 32'h1234);
    end
    check("idle_keeps_dcx", 32'(dcx[0]), 1);

    // Burst of three held-valid words
    @(posedge clk); #1;
    base = done_cnt[0];
    send(0, 1'b1, 16'h1111, 0, a);
    chk_csx = 1'b1;
    send(0, 1'b0, 16'h2222, 5, a);
    send(0, 1'b1, 16'h3333, 5, a);
    wait_done(0, base + 3);
    chk_csx = 1'b0;
    check("burst_csx_continuous", csx_breaks, 0);
    repeat (3) @(posedge clk); #1;

    // Backpressure: second word offered during WR_LOW
    base = done_cnt[0];
    send(0, 1'b1, 16'hAAAA, 0, a);
    wait_wrx_low(0);
    send(0, 1'b0, 16'h5555, 0, acc_b);
    check("bp_accept_final_wrh", acc_b, last_done[0] + 1);
    wait_done(0, base + 2);
    repeat (3) @(posedge clk); #1;

    // Reset during WR_LOW, then a normal write
    base = done_cnt[0];
    send(0, 1'b1, 16'hDEAD, 0, a);
    wait_wrx_low(0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_csx", 32'(csx[0]), 1);
    check("async_rst_wrx", 32'(wrx[0]), 1);
    check("async_rst_busy", 32'(busy[0]), 0);
    q0.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    repeat (6) begin
      @(negedge clk);
      if (!wrx[0]) lows++;
    end
    check("rst_no_wrx_edge", lows, 0);
    check("rst_no_done", done_cnt[0], base);
    @(posedge clk); #1;
    send(0, 1'b0, 16'h0F0F, 0, a);
    wait_done(0, base + 1);

    // Swept timing instance: command then data word back-to-back
    base = done_cnt[1];
    send(1, 1'b0, 16'h00A5, 0, a);
    send(1, 1'b1, 16'hBEEF, 8, a);
    wait_done(1, base + 2);

    repeat (10) @(posedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/i8080_tx.md
I8080_TX -- requirements
Module: i8080_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning i8080 data bus width.
REQ-002 SHALL have parameter T_SETUP, default 1, meaning cycles CSX/DCX/DB are valid before WRX falls (range 1..255).
REQ-003 SHALL have parameter T_WRL, default 2, meaning WRX low cycles (range 1..255).
REQ-004 SHALL have parameter T_WRH, default 2, meaning WRX high cycles after the rising edge (range 1..255).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1, meaning a word is offered.
REQ-008 SHALL have port in_dc, input, 1, meaning 0 = command and 1 = data.
REQ-009 SHALL have port in_data, input, DATA_W, meaning the word to write.
REQ-010 SHALL have port in_ready, output, 1, meaning a word is accepted when in_valid and in_ready are both high on a clk edge.
REQ-011 SHALL have ports csx, dcx and wrx, each output, 1, meaning the i8080 chip select, data/command select and write strobe, all active-low except dcx.
REQ-012 SHALL have port db, output, DATA_W, meaning the i8080 data bus (write-only).
REQ-013 SHALL have port busy, output, 1, meaning high whenever the state is not IDLE.
REQ-014 SHALL have port done, output, 1, meaning a one-cycle pulse on the cycle WRX rises.

Function
REQ-015 SHALL drive all outputs from registers.
REQ-016 SHALL implement the states IDLE, SETUP, WR_LOW and WR_HIGH, with an 8-bit down-counter for the phase length.
REQ-017 In IDLE: csx=1, wrx=1, in_ready=1; an accepted word latches in_dc/in_data into dcx/db, sets csx=0 and moves to SETUP.
REQ-018 SETUP SHALL hold wrx=1 for T_SETUP cycles, then move to WR_LOW.
REQ-019 WR_LOW SHALL hold wrx=0 for T_WRL cycles, then move to WR_HIGH.
REQ-020 On entry to WR_HIGH, wrx SHALL rise, done SHALL pulse, and db/dcx SHALL stay stable for all T_WRH cycles.
REQ-021 in_ready SHALL be high only in IDLE and in the final WR_HIGH cycle.
REQ-022 A word accepted in the final WR_HIGH cycle SHALL latch new db/dcx and go to SETUP with csx held 0 (burst).
REQ-023 If no word is accepted in the final WR_HIGH cycle, the block SHALL return to IDLE with csx=1.
REQ-024 in_valid while in_ready is low SHALL be ignored; the upstream holds the word until accepted.
REQ-025 Word period in a burst SHALL be exactly T_SETUP+T_WRL+T_WRH cycles.
REQ-026 db and dcx SHALL retain the last written value in IDLE.

Reset
REQ-027 On reset assertion, the block SHALL immediately enter IDLE with csx=1, wrx=1, dcx=1, db=0, done=0, busy=0, in_ready=0 and counter=0.
REQ-028 in_ready SHALL go high on the first clk edge after reset deassertion.
REQ-029 Reset mid-write SHALL abort the transfer with no done pulse and no further WRX edge.

Structure
REQ-030 The state encoding and timing-parameter defaults SHALL live in a shared package, i8080_pkg.
REQ-031 The block SHALL be a single module with no sub-modules.

Verification
REQ-032 Single write (defaults): with 0x1234 and dc=1 accepted at cycle 0, csx SHALL be low for cycles 1-5, wrx low for cycles 2-3, done high at cycle 4, and db=0x1234 throughout.
REQ-033 Burst: with 3 words held valid, csx SHALL stay low continuously, there SHALL be 3 WRX pulses exactly 5 cycles apart, and db SHALL show each word in order.
REQ-034 Backpressure: with in_valid high during WR_LOW, the word SHALL NOT be accepted until the final WR_HIGH cycle, and db SHALL remain unchanged while wrx=0.
REQ-035 Reset during WR_LOW: assert reset, then csx=1 and wrx=1 SHALL follow asynchronously, with no done pulse; a write issued after reset SHALL complete normally.
REQ-036 Parameter sweep: with T_SETUP=3, T_WRL=1, T_WRH=4, wrx low SHALL last 1 cycle, the word period SHALL be 8 cycles, and a command word SHALL show dcx=0.
